// File: rtl/array_result_drain.sv
// Snapshots sixteen array accumulators, clears the array, then drains the words.
// Define ARRAY_RESULT_DRAIN_PARITY_EN to drive even parity on out_data[31].
module array_result_drain #(
  parameter int CLR_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [271:0] fc_flat,
  input  logic         capture,
  output logic         acc_resetn,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [16:0] snap [16];
  logic [3:0]  idx;
  logic [3:0]  idx_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        done_q;
  logic        done_nx;
  logic        take;
  logic [30:0] word;
  logic        par;

  assign take = (state == IDLE) && capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 4'd0;
      cnt    <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end

  // Snapshot lands on the same edge that enters CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        snap[i] <= 17'd0;
    end else if (take) begin
      for (int i = 0; i < 16; i++)
        snap[i] <= fc_flat[17*i +: 17];
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture) begin
          state_nx = CLEAR;
          cnt_nx   = 4'(CLR_CYCLES - 1);
          idx_nx   = 4'd0;
        end
      end
      CLEAR: begin
        if (cnt == 4'd0)
          state_nx = DRAIN;
        else
          cnt_nx = cnt - 4'd1;
      end
      DRAIN: begin
        if (out_ready) begin
          idx_nx = idx + 4'd1;
          if (idx == 4'd15) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign word = {10'b0, idx, snap[idx]};

`ifdef ARRAY_RESULT_DRAIN_PARITY_EN
  assign par = ^word;
`else
  assign par = 1'b0;
`endif

  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? {par, word} : 32'd0;
  assign out_last   = out_valid && (idx == 4'd15);
  assign busy       = (state != IDLE);
  assign acc_resetn = (state != CLEAR);
  assign done       = done_q;

endmodule
